mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one unified memory port between the core's instruction-fetch port (IAD/IDT/ACKI_n)
//  and data port (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). Sits between top and the memory model.
//  Serialises requests into single memory transactions and returns data plus a one-cycle
//  active-low acknowledge to the winner. Data accesses have priority; fairness is optional.
// PARAMETERS
//  BIT_WIDTH    32  address/data width
//  STARVE_LIMIT  4  consecutive data grants before a pending fetch is forced (fairness only)
// PORTS
//  clk      in   1          system clock, rising edge
//  rst      in   1          asynchronous, active-high reset
//  i_req    in   1          instruction fetch request (level, held until i_ack_n low)
//  i_addr   in   BIT_WIDTH  fetch address
//  i_rdata  out  BIT_WIDTH  fetched word
//  i_ack_n  out  1          fetch acknowledge, active low, one-cycle pulse
//  d_req    in   1          data request (MREQ), held until d_ack_n low
//  d_write  in   1          1 = store, 0 = load
//  d_size   in   2          00 word, 01 half, 1x byte
//  d_addr   in   BIT_WIDTH  data address
//  d_wdata  in   BIT_WIDTH  store data, right-aligned for half/byte
//  d_rdata  out  BIT_WIDTH  load data, zero-extended by memory
//  d_ack_n  out  1          data acknowledge, active low, one-cycle pulse
//  m_req    out  1          memory request
//  m_write  out  1          memory write enable
//  m_size   out  2          memory access size (fetch always 00)
//  m_addr   out  BIT_WIDTH  memory address
//  m_wdata  out  BIT_WIDTH  memory write data (0 when not writing)
//  m_rdata  in   BIT_WIDTH  memory read data, valid when m_ack_n low
//  m_ack_n  in   1          memory acknowledge, active low
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, m_req=0, m_write=0, m_size=00, m_addr=0,
//    m_wdata=0, i_ack_n=1, d_ack_n=1, i_rdata=0, d_rdata=0, starve count=0.
//  - FSM IDLE -> GRANT_I | GRANT_D -> IDLE. IDLE: d_req wins over i_req; winner's
//    addr/size/write/wdata latched, m_req=1 from next cycle. Neither: stay IDLE, m_req=0.
//  - GRANT_x: m_req/m_addr/m_size/m_write/m_wdata held stable. Edge sampling m_ack_n=0:
//    m_rdata into x_rdata (loads/fetches; stores leave d_rdata unchanged), x_ack_n=0 for
//    exactly one cycle, m_req=0, return to IDLE.
//  - Latency: req seen at edge N -> m_req high after N; m_ack_n low at edge N+k (k>=1) ->
//    x_ack_n low after N+k. One idle turnaround cycle minimum between transactions.
//  - Both requests in same IDLE cycle: data granted; fetch waits (req still held).
//  - Requester drops req mid-grant: transaction still completes, ack pulse still issued.
//  - x_rdata holds its value until the next acknowledged read on the same port.
//  - m_ack_n low outside GRANT_x: ignored. No timeout; memory must eventually ack.
//  - rst asserted mid-transaction: immediate return to reset values, transaction abandoned.
// CONFIGURATION
//  MEM_ARB_FAIRNESS_EN defined: counter increments on each data grant made while i_req=1,
//    clears on each fetch grant; at STARVE_LIMIT the next IDLE decision grants fetch even
//    if d_req=1. Counter saturates, reset to 0.
//  Not defined: strict data priority; counter logic absent; fetch may starve indefinitely.
// TESTING
//  1 fetch only: i_req=1,i_addr=0x100, mem acks 1 cycle after m_req, m_rdata=0x20010005
//    -> m_addr=0x100,m_size=00,m_write=0; i_ack_n low 1 cycle, i_rdata=0x20010005.
//  2 store byte: d_req=1,d_write=1,d_size=10,d_addr=0xF0000000,d_wdata=0x41
//    -> m_write=1,m_size=10,m_wdata=0x41; d_ack_n pulse; d_rdata unchanged.
//  3 simultaneous i_req/d_req (load 0x200) -> data served first, fetch granted after the
//    turnaround cycle; each ack exactly once, in that order.
//  4 memory latency 3 cycles -> m_req/m_addr stable 3 cycles, single ack pulse, no early ack.
//  5 fairness: d_req held high with i_req high -> with MEM_ARB_FAIRNESS_EN fetch granted
//    after 4 data grants; without the macro no fetch grant in 20 transactions.
//  6 rst pulsed while in GRANT_D awaiting ack -> all outputs at reset values immediately;
//    late m_ack_n ignored; next request served normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between an instruction-fetch port and
//               a data port. Each request becomes a single memory transaction.
//               The winner gets its read data and a one-cycle active-low
//               acknowledge. Data requests have priority over fetches.
//               Optional fetch fairness is enabled by defining the macro
//               MEM_ARB_FAIRNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int BIT_WIDTH    = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   // instruction fetch port
   input  logic                 i_req,
   input  logic [BIT_WIDTH-1:0] i_addr,
   output logic [BIT_WIDTH-1:0] i_rdata,
   output logic                 i_ack_n,
   // data port
   input  logic                 d_req,
   input  logic                 d_write,
   input  logic [1:0]           d_size,
   input  logic [BIT_WIDTH-1:0] d_addr,
   input  logic [BIT_WIDTH-1:0] d_wdata,
   output logic [BIT_WIDTH-1:0] d_rdata,
   output logic                 d_ack_n,
   // unified memory port
   output logic                 m_req,
   output logic                 m_write,
   output logic [1:0]           m_size,
   output logic [BIT_WIDTH-1:0] m_addr,
   output logic [BIT_WIDTH-1:0] m_wdata,
   input  logic [BIT_WIDTH-1:0] m_rdata,
   input  logic                 m_ack_n
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2
   } state_t;

   state_t                 state_q,   state_d;
   logic                   m_req_q,   m_req_d;
   logic                   m_write_q, m_write_d;
   logic [1:0]             m_size_q,  m_size_d;
   logic [BIT_WIDTH-1:0]   m_addr_q,  m_addr_d;
   logic [BIT_WIDTH-1:0]   m_wdata_q, m_wdata_d;
   logic                   i_ack_n_q, i_ack_n_d;
   logic                   d_ack_n_q, d_ack_n_d;
   logic [BIT_WIDTH-1:0]   i_rdata_q, i_rdata_d;
   logic [BIT_WIDTH-1:0]   d_rdata_q, d_rdata_d;

   // A requester still sees its ack low during the cycle after completion and
   // has not yet dropped its request; arbitration waits until both acks are
   // released so a finished request is never granted a second time. This is
   // also the idle turnaround cycle between transactions.
   logic w_arb_ok;
   assign w_arb_ok = i_ack_n_q & d_ack_n_q;

   logic w_force_fetch;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int              C_STARVE_CW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [C_STARVE_CW-1:0] C_STARVE_MAX = C_STARVE_CW'(STARVE_LIMIT);

   logic [C_STARVE_CW-1:0] starve_q, starve_d;

   // A pending fetch is forced through once enough data grants have passed it.
   assign w_force_fetch = (starve_q >= C_STARVE_MAX);
`else
   // Strict data priority: a fetch is never forced ahead of data.
   assign w_force_fetch = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_write_d = m_write_q;
      m_size_d  = m_size_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_ack_n_d = 1'b1;
      d_ack_n_d = 1'b1;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_FAIRNESS_EN
      starve_d  = starve_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (w_arb_ok) begin
               if (i_req && (w_force_fetch || !d_req)) begin
                  state_d   = S_GRANT_I;
                  m_req_d   = 1'b1;
                  m_write_d = 1'b0;
                  m_size_d  = 2'b00;
                  m_addr_d  = i_addr;
                  m_wdata_d = '0;
`ifdef MEM_ARB_FAIRNESS_EN
                  starve_d  = '0;
`endif
               end else if (d_req) begin
                  state_d   = S_GRANT_D;
                  m_req_d   = 1'b1;
                  m_write_d = d_write;
                  m_size_d  = d_size;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_write ? d_wdata : '0;
`ifdef MEM_ARB_FAIRNESS_EN
                  if (i_req && (starve_q != C_STARVE_MAX)) begin
                     starve_d = starve_q + C_STARVE_CW'(1);
                  end
`endif
               end
            end
         end

         S_GRANT_I: begin
            if (!m_ack_n) begin
               i_rdata_d = m_rdata;
               i_ack_n_d = 1'b0;
               m_req_d   = 1'b0;
               m_write_d = 1'b0;
               m_wdata_d = '0;
               state_d   = S_IDLE;
            end
         end

         S_GRANT_D: begin
            if (!m_ack_n) begin
               // stores leave the previous load data visible
               if (!m_write_q) begin
                  d_rdata_d = m_rdata;
               end
               d_ack_n_d = 1'b0;
               m_req_d   = 1'b0;
               m_write_d = 1'b0;
               m_wdata_d = '0;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers, asynchronously reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         m_req_q   <= 1'b0;
         m_write_q <= 1'b0;
         m_size_q  <= 2'b00;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_ack_n_q <= 1'b1;
         d_ack_n_q <= 1'b1;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_write_q <= m_write_d;
         m_size_q  <= m_size_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_ack_n_q <= i_ack_n_d;
         d_ack_n_q <= d_ack_n_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_FAIRNESS_EN
   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   assign m_req   = m_req_q;
   assign m_write = m_write_q;
   assign m_size  = m_size_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_ack_n = i_ack_n_q;
   assign d_ack_n = d_ack_n_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Expected transactions
//               are queued when requests are issued; the memory responder
//               checks each transaction start, and every acknowledge is checked
//               against the queue in order. Honours MEM_ARB_FAIRNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int BW = 32;

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [BW-1:0] i_addr;
   logic [BW-1:0] i_rdata;
   logic          i_ack_n;
   logic          d_req;
   logic          d_write;
   logic [1:0]    d_size;
   logic [BW-1:0] d_addr;
   logic [BW-1:0] d_wdata;
   logic [BW-1:0] d_rdata;
   logic          d_ack_n;
   logic          m_req;
   logic          m_write;
   logic [1:0]    m_size;
   logic [BW-1:0] m_addr;
   logic [BW-1:0] m_wdata;
   logic [BW-1:0] r_mem_rdata;
   logic          r_mem_ack_n;
   logic          r_inj_ack;
   logic          w_m_ack_n;

   assign w_m_ack_n = r_mem_ack_n & ~r_inj_ack;

   mem_bus_arbiter #(.BIT_WIDTH(BW), .STARVE_LIMIT(4)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack_n (i_ack_n),
      .d_req   (d_req),
      .d_write (d_write),
      .d_size  (d_size),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack_n (d_ack_n),
      .m_req   (m_req),
      .m_write (m_write),
      .m_size  (m_size),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (r_mem_rdata),
      .m_ack_n (w_m_ack_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t start_q[$];
   txn_t ack_q[$];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic [31:0] cur_addr = '0;
   logic [31:0] model_d  = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h2001_0005;
      return (a ^ 32'hC3C3_0000) + 32'd1;
   endfunction

   task automatic push_txn(input bit is_d, input bit wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
      txn_t t;
      t.is_d  = is_d;
      t.wr    = wr;
      t.size  = is_d ? sz : 2'b00;
      t.addr  = a;
      t.wdata = wr ? wd : 32'd0;
      start_q.push_back(t);
      ack_q.push_back(t);
   endtask

   // Issue a data request and hold it until acknowledged.
   task automatic do_d(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
      bit got;
      got     = 1'b0;
      d_write = wr;
      d_size  = sz;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (d_ack_n == 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_eq("d_ack_timeout", 32'd0, 32'd1);
      d_req = 1'b0;
   endtask

   // Issue a fetch request and hold it until acknowledged.
   task automatic do_i(input logic [31:0] a);
      bit got;
      got    = 1'b0;
      i_addr = a;
      i_req  = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (i_ack_n == 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_eq("i_ack_timeout", 32'd0, 32'd1);
      i_req = 1'b0;
   endtask

   // Acknowledge scoreboard followed by the memory responder, both on negedge.
   initial begin
      txn_t        t;
      logic [31:0] e;
      r_mem_ack_n = 1'b1;
      r_mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!i_ack_n || !d_ack_n) begin
            check_eq("ack_both_low", {31'd0, i_ack_n | d_ack_n}, 32'd1);
            check_eq("ack_timing", {31'd0, r_mem_ack_n}, 32'd0);
            if (ack_q.size() == 0) begin
               check_eq("spurious_ack", 32'd1, 32'd0);
            end else begin
               t = ack_q.pop_front();
               check_eq("ack_port_is_d", {31'd0, ~d_ack_n}, {31'd0, t.is_d});
               if (t.is_d) begin
                  if (!t.wr) model_d = memf(t.addr);
                  check_eq("d_rdata", d_rdata, model_d);
               end else begin
                  e = memf(t.addr);
                  check_eq("i_rdata", i_rdata, e);
               end
            end
         end
         if (m_req) begin
            if (mem_cnt == 0) begin
               if (start_q.size() == 0) begin
                  check_eq("unexpected_m_req", 32'd1, 32'd0);
               end else begin
                  t = start_q.pop_front();
                  check_eq("m_addr", m_addr, t.addr);
                  check_eq("m_size", {30'd0, m_size}, {30'd0, t.size});
                  check_eq("m_write", {31'd0, m_write}, {31'd0, t.wr});
                  check_eq("m_wdata", m_wdata, t.wdata);
               end
               cur_addr = m_addr;
            end else begin
               check_eq("m_addr_stable", m_addr, cur_addr);
            end
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
               r_mem_ack_n = 1'b0;
               r_mem_rdata = memf(cur_addr);
            end else begin
               r_mem_ack_n = 1'b1;
            end
         end else begin
            mem_cnt     = 0;
            r_mem_ack_n = 1'b1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      rst = 1'b1; r_inj_ack = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check_eq("rst_m_req",   {31'd0, m_req},   32'd0);
      check_eq("rst_m_write", {31'd0, m_write}, 32'd0);
      check_eq("rst_m_size",  {30'd0, m_size},  32'd0);
      check_eq("rst_m_addr",  m_addr,  32'd0);
      check_eq("rst_m_wdata", m_wdata, 32'd0);
      check_eq("rst_i_ack_n", {31'd0, i_ack_n}, 32'd1);
      check_eq("rst_d_ack_n", {31'd0, d_ack_n}, 32'd1);
      check_eq("rst_i_rdata", i_rdata, 32'd0);
      check_eq("rst_d_rdata", d_rdata, 32'd0);

      // 1: fetch only
      push_txn(1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'd0);
      do_i(32'h0000_0100);
      check_eq("t1_i_rdata", i_rdata, 32'h2001_0005);
      repeat (2) @(negedge clk);

      // 2: store byte leaves d_rdata untouched
      push_txn(1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041);
      do_d(1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041);
      check_eq("t2_d_rdata", d_rdata, 32'd0);
      repeat (2) @(negedge clk);

      // 3: simultaneous requests, data first
      push_txn(1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'd0);
      push_txn(1'b0, 1'b0, 2'b00, 32'h0000_0104, 32'd0);
      fork
         do_d(1'b0, 2'b00, 32'h0000_0200, 32'd0);
         do_i(32'h0000_0104);
      join
      repeat (2) @(negedge clk);

      // 4: three-cycle memory latency, half-word load
      mem_lat = 3;
      push_txn(1'b1, 1'b0, 2'b01, 32'h0000_0344, 32'd0);
      do_d(1'b0, 2'b01, 32'h0000_0344, 32'd0);
      mem_lat = 1;
      repeat (2) @(negedge clk);

      // 6: reset while waiting for a data ack
      mem_lat = 1000;
      push_txn(1'b1, 1'b1, 2'b00, 32'h0000_0500, 32'hDEAD_BEEF);
      d_write = 1'b1; d_size = 2'b00; d_addr = 32'h0000_0500; d_wdata = 32'hDEAD_BEEF;
      d_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (m_req) begin
            got = 1'b1;
            break;
         end
      end
      check_eq("t6_m_req_seen", {31'd0, got}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      model_d = '0;
      check_eq("t6_rst_m_req",   {31'd0, m_req},   32'd0);
      check_eq("t6_rst_m_write", {31'd0, m_write}, 32'd0);
      check_eq("t6_rst_m_addr",  m_addr,  32'd0);
      check_eq("t6_rst_m_wdata", m_wdata, 32'd0);
      check_eq("t6_rst_d_ack_n", {31'd0, d_ack_n}, 32'd1);
      check_eq("t6_rst_d_rdata", d_rdata, 32'd0);
      check_eq("t6_rst_i_rdata", i_rdata, 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      void'(ack_q.pop_back());
      mem_lat = 1;
      r_inj_ack = 1'b1;
      @(negedge clk);
      r_inj_ack = 1'b0;
      check_eq("t6_late_m_req",   {31'd0, m_req},   32'd0);
      check_eq("t6_late_d_ack_n", {31'd0, d_ack_n}, 32'd1);
      check_eq("t6_late_i_ack_n", {31'd0, i_ack_n}, 32'd1);
      @(negedge clk);
      push_txn(1'b1, 1'b0, 2'b00, 32'h0000_0504, 32'd0);
      do_d(1'b0, 2'b00, 32'h0000_0504, 32'd0);
      repeat (2) @(negedge clk);

      // 5: data held continuously while a fetch waits
      for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
         if (k == 4) push_txn(1'b0, 1'b0, 2'b00, 32'h0000_0400, 32'd0);
`endif
         push_txn(1'b1, 1'b0, 2'b00, 32'h0000_3000 + 32'(k) * 32'd4, 32'd0);
      end
`ifndef MEM_ARB_FAIRNESS_EN
      push_txn(1'b0, 1'b0, 2'b00, 32'h0000_0400, 32'd0);
`endif
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               do_d(1'b0, 2'b00, 32'h0000_3000 + 32'(k) * 32'd4, 32'd0);
            end
         end
         do_i(32'h0000_0400);
      join
      repeat (4) @(negedge clk);

      check_eq("start_q_empty", 32'(start_q.size()), 32'd0);
      check_eq("ack_q_empty",   32'(ack_q.size()),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
